uart_i2c_cmd_receiver: RTL

- Parses command frames sent from the PC through the UART core's receive side.
- Validates each frame and writes one decoded instruction (register address, operation, write data) into the instruction FIFO consumed by the I2C temp-sensor controller.
- Reverse path of the I2C-to-UART frame transmitter; uses the same byte framing: start 0xFF, address, operation, data bytes low-first, stop 0xFF.

---
 rtl/uart_i2c_cmd_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_i2c_cmd_receiver.sv
// Command-frame parser: FF, addr, op, data (low byte first), FF from the UART RX side
// is decoded into one instruction write to the I2C controller's instruction FIFO.
module uart_i2c_cmd_receiver #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [7:0]  instr_addr,
    output logic [7:0]  instr_op,
    output logic [15:0] instr_data,
    output logic        busy,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_OP,
        S_DATA1,
        S_DATA2,
        S_STOP
    } state_t;

    localparam logic [7:0]       FRAME_BYTE = 8'hFF;
    // Expiry is detected one count early so the pulse lands TIMEOUT_CYCLES cycles after the last byte.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        op_q, op_d;
    logic [15:0]       data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_err_q, overflow_err_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        op_d           = op_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        fifo_wr_d      = 1'b0;
        frame_err_d    = 1'b0;
        overflow_err_d = 1'b0;
        timeout_err_d  = 1'b0;

        if (state_q == S_IDLE || rx_done_tick) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
            cnt_d         = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A received byte overrides any simultaneous timeout decided above.
        if (rx_done_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == FRAME_BYTE) state_d = S_ADDR;
                end
                S_ADDR: begin
                    addr_d  = rx_data;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = rx_data;
                    data_d  = '0;
                    state_d = (rx_data[2:1] == 2'b01) ? S_DATA1 : S_STOP;
                end
                S_DATA1: begin
                    data_d[7:0] = rx_data;
                    state_d     = op_q[0] ? S_DATA2 : S_STOP;
                end
                S_DATA2: begin
                    data_d[15:8] = rx_data;
                    state_d      = S_STOP;
                end
                S_STOP: begin
                    if (rx_data != FRAME_BYTE) frame_err_d    = 1'b1;
                    else if (fifo_full)        overflow_err_d = 1'b1;
                    else                       fifo_wr_d      = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            op_q           <= '0;
            data_q         <= '0;
            cnt_q          <= '0;
            fifo_wr_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            overflow_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            op_q           <= op_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            fifo_wr_q      <= fifo_wr_d;
            frame_err_q    <= frame_err_d;
            overflow_err_q <= overflow_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign fifo_wr      = fifo_wr_q;
    assign frame_err    = frame_err_q;
    assign overflow_err = overflow_err_q;
    assign timeout_err  = timeout_err_q;
    assign instr_addr   = addr_q;
    assign instr_op     = op_q;
    assign instr_data   = data_q;
    assign busy         = (state_q != S_IDLE);

endmodule
